cim_seq_ctrl: RTL and testbench

- Command-level sequencer for the CIM compute datapath.
- Accepts one MAC-batch command per handshake and drives the datapath mode (InFp), phase count (cnt) and DataValid strobe.
- Waits for the datapath done pulse, then captures the INT or FP results into a valid/ready result register.
- Sits between the SoC-side CIM register/DMA front end and the compute datapath instance.

---
 rtl/cim_seq_pkg.sv | 34 +++
 rtl/cim_seq_timer.sv | 30 +++
 rtl/cim_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_cim_seq_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_seq_pkg.sv
// Shared types and constants for the CIM command sequencer.
//   state_e   : sequencer states
//   CNT_IDLE  : phase count driven while the datapath is not sequencing
//   fp_res_t  : packed {FP3,FP2,FP1,FP0} result word from the datapath
//   sext_int  : sign-extends the 22-bit INT result to 32 bits
package cim_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StRun,
    StWait,
    StResp
  } state_e;

  localparam logic [3:0] CNT_IDLE = 4'hF;

  localparam int unsigned LAST_INT_DEF    = 6;
  localparam int unsigned LAST_FP_DEF     = 10;
  localparam int unsigned FLUSH_CYC_DEF   = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef struct packed {
    logic [7:0] fp3;
    logic [7:0] fp2;
    logic [7:0] fp1;
    logic [7:0] fp0;
  } fp_res_t;

  function automatic logic [31:0] sext_int(input logic [21:0] v);
    return {{10{v[21]}}, v};
  endfunction

endpackage

// File: rtl/cim_seq_timer.sv
// Shared down-counter for the FLUSH drain period and the WAIT timeout.
//   clk, RSTN : clock, asynchronous active-low reset
//   load      : load load_val this edge (wins over counting)
//   load_val  : value loaded; expire rises load_val cycles after the load edge
//   expire    : counter is at zero
module cim_seq_timer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/cim_seq_ctrl.sv
// Command-level sequencer for the CIM compute datapath.
// Accepts one MAC-batch command, drives mode/phase count/DataValid to the
// datapath, waits for its done pulse (or times out) and holds the result in a
// valid/ready register.
//   clk, RSTN          : clock, asynchronous active-low reset
//   cmd_valid/ready    : command handshake, cmd_fp selects FP (1) or INT (0)
//   cim_infp           : datapath mode, changes only on command accept
//   cim_data_valid     : high while the phase count is sequencing
//   cim_cnt            : phase count, 4'hF when idle
//   cim_done           : datapath done pulse, only observed in WAIT
//   cim_int, cim_fp    : datapath INT / FP results
//   res_valid/ready    : result handshake; res_fp, res_data, res_err describe it
//   busy               : sequencer is not idle
// Optional build macro CIM_SEQ_PERF_EN adds perf_clr, perf_ops, perf_cycles.
module cim_seq_ctrl
  import cim_seq_pkg::*;
#(
  parameter int unsigned LAST_INT    = LAST_INT_DEF,
  parameter int unsigned LAST_FP     = LAST_FP_DEF,
  parameter int unsigned FLUSH_CYC   = FLUSH_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_fp,
  output logic        cim_infp,
  output logic        cim_data_valid,
  output logic [3:0]  cim_cnt,
  input  logic        cim_done,
  input  logic [21:0] cim_int,
  input  logic [31:0] cim_fp,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_fp,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy
`ifdef CIM_SEQ_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_cycles
`endif
);

  localparam int unsigned TMR_MAX = (FLUSH_CYC > TIMEOUT_CYC) ? FLUSH_CYC : TIMEOUT_CYC;
  localparam int unsigned TW      = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  state_e        state_q, state_d;
  logic          infp_q, infp_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d;
  logic          res_err_q, res_err_d;
  logic          res_fp_q, res_fp_d;
  logic [31:0]   res_data_q, res_data_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expire;

  fp_res_t       fp_res;
  logic [3:0]    last_cnt;

  assign fp_res   = cim_fp;
  assign last_cnt = infp_q ? 4'(LAST_FP) : 4'(LAST_INT);

  cim_seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .RSTN     (RSTN),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= StIdle;
      infp_q      <= 1'b0;
      cnt_q       <= CNT_IDLE;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_fp_q    <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      infp_q      <= infp_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_fp_q    <= res_fp_d;
      res_data_q  <= res_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    infp_d      = infp_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    res_fp_d    = res_fp_q;
    res_data_d  = res_data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          infp_d = cmd_fp;
          if (cmd_fp != infp_q) begin
            // Mode change: drain the FP buffers and adder tree first.
            state_d  = StFlush;
            tmr_load = 1'b1;
            tmr_val  = TW'(FLUSH_CYC - 1);
          end else begin
            state_d = StRun;
            cnt_d   = 4'd0;
          end
        end
      end
      StFlush: begin
        if (tmr_expire) begin
          state_d = StRun;
          cnt_d   = 4'd0;
        end
      end
      StRun: begin
        if (cnt_q == last_cnt) begin
          state_d  = StWait;
          cnt_d    = CNT_IDLE;
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYC - 1);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWait: begin
        // Done has priority over a coincident timeout.
        if (cim_done) begin
          state_d     = StResp;
          res_valid_d = 1'b1;
          res_err_d   = 1'b0;
          res_fp_d    = infp_q;
          res_data_d  = infp_q ? fp_res : sext_int(cim_int);
        end else if (tmr_expire) begin
          state_d     = StResp;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_data_d  = '0;
        end
      end
      StResp: begin
        if (res_ready) begin
          state_d     = StIdle;
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    cmd_ready      = (state_q == StIdle);
    busy           = (state_q != StIdle);
    cim_data_valid = (state_q == StRun);
  end

  assign cim_infp  = infp_q;
  assign cim_cnt   = cnt_q;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign res_fp    = res_fp_q;
  assign res_data  = res_data_q;

`ifdef CIM_SEQ_PERF_EN
  logic [31:0] perf_ops_q, perf_cycles_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      perf_ops_q    <= '0;
      perf_cycles_q <= '0;
    end else if (perf_clr) begin
      perf_ops_q    <= '0;
      perf_cycles_q <= '0;
    end else begin
      if (res_valid_q && res_ready && !res_err_q && (perf_ops_q != '1)) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if (busy && (perf_cycles_q != '1)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
    end
  end

  assign perf_ops    = perf_ops_q;
  assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_cim_seq_ctrl.sv
// Bench for cim_seq_ctrl: a timeline model (accept edge -> run start -> wait
// start -> result edge) is checked against the DUT on every falling edge,
// alongside directed scenarios with literal expectations.
module tb_cim_seq_ctrl;

  localparam int L_INT   = 6;
  localparam int L_FP    = 10;
  localparam int FLUSH   = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_fp = 1'b0;
  logic        cmd_ready;
  logic        cim_infp;
  logic        cim_data_valid;
  logic [3:0]  cim_cnt;
  logic        cim_done = 1'b0;
  logic [21:0] cim_int = '0;
  logic [31:0] cim_fp = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_fp;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;
`ifdef CIM_SEQ_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_ops;
  logic [31:0] perf_cycles;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cim_seq_ctrl dut (
    .clk            (clk),
    .RSTN           (RSTN),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_fp         (cmd_fp),
    .cim_infp       (cim_infp),
    .cim_data_valid (cim_data_valid),
    .cim_cnt        (cim_cnt),
    .cim_done       (cim_done),
    .cim_int        (cim_int),
    .cim_fp         (cim_fp),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_fp         (res_fp),
    .res_data       (res_data),
    .res_err        (res_err),
    .busy           (busy)
`ifdef CIM_SEQ_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_ops       (perf_ops),
    .perf_cycles    (perf_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int          e_n = 0;      // index of the last rising edge
  logic        e_active = 1'b0;
  logic        e_mode = 1'b0;
  int          t_run = 0;    // edge after which the count shows 0
  int          t_wait = 0;   // edge after which WAIT is entered
  logic        e_rv = 1'b0;
  logic        e_err = 1'b0;
  logic        e_fp = 1'b0;
  logic [31:0] e_data = '0;

  function automatic int run_edge(input int edge_idx, input logic fp, input logic mode);
    return edge_idx + ((fp != mode) ? FLUSH : 0);
  endfunction

  always @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      e_n <= 0; e_active <= 1'b0; e_mode <= 1'b0; t_run <= 0; t_wait <= 0;
      e_rv <= 1'b0; e_err <= 1'b0; e_fp <= 1'b0; e_data <= '0;
    end else begin
      e_n <= e_n + 1;
      if (e_rv) begin
        if (res_ready) begin
          e_rv <= 1'b0; e_err <= 1'b0; e_active <= 1'b0;
        end
      end else if (e_active) begin
        if (e_n + 1 > t_wait) begin
          if (cim_done) begin
            e_rv <= 1'b1; e_err <= 1'b0; e_fp <= e_mode;
            e_data <= e_mode ? cim_fp : 32'($signed(cim_int));
          end else if (e_n + 1 == t_wait + TIMEOUT) begin
            e_rv <= 1'b1; e_err <= 1'b1; e_data <= '0;
          end
        end
      end else if (cmd_valid) begin
        e_active <= 1'b1;
        e_mode   <= cmd_fp;
        t_run    <= run_edge(e_n + 1, cmd_fp, e_mode);
        t_wait   <= run_edge(e_n + 1, cmd_fp, e_mode) + (cmd_fp ? L_FP : L_INT) + 1;
      end
    end
  end

  // Compare on every falling edge.
  always @(negedge clk) begin
    logic       x_dv;
    logic [3:0] x_cnt;
    x_dv  = e_active && !e_rv && (e_n >= t_run) && (e_n < t_wait);
    x_cnt = x_dv ? 4'(e_n - t_run) : 4'hF;
    chk("cmd_ready", 32'(cmd_ready), 32'(!e_active));
    chk("busy", 32'(busy), 32'(e_active));
    chk("cim_infp", 32'(cim_infp), 32'(e_mode));
    chk("cim_data_valid", 32'(cim_data_valid), 32'(x_dv));
    chk("cim_cnt", 32'(cim_cnt), 32'(x_cnt));
    chk("res_valid", 32'(res_valid), 32'(e_rv));
    chk("res_err", 32'(res_err), 32'(e_err));
    chk("res_fp", 32'(res_fp), 32'(e_fp));
    chk("res_data", res_data, e_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic fp);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_fp    = fp;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns at the first falling edge in WAIT.
  task automatic run_phase(output int flush_n, output int dv_n,
                           output logic [3:0] first_cnt, output logic [3:0] last_cnt);
    flush_n = 0;
    dv_n = 0;
    last_cnt = 4'hF;
    while (!cim_data_valid && flush_n < 50) begin
      flush_n++;
      @(negedge clk);
    end
    first_cnt = cim_cnt;
    while (cim_data_valid && dv_n < 50) begin
      dv_n++;
      last_cnt = cim_cnt;
      @(negedge clk);
    end
  endtask

  task automatic pulse_done(input logic [21:0] iv, input logic [31:0] fv);
    cim_int  = iv;
    cim_fp   = fv;
    cim_done = 1'b1;
    @(negedge clk);
    cim_done = 1'b0;
  endtask

  task automatic wait_res(output int k);
    k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid) chk("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic take();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int fl, dv, k;
    logic [3:0] c0, cl;

    repeat (3) @(negedge clk);
    chk("reset_cnt", 32'(cim_cnt), 32'hF);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_res_data", res_data, 32'd0);
    RSTN = 1'b1;
    @(negedge clk);

    // INT batch, no flush needed.
    send(1'b0);
    run_phase(fl, dv, c0, cl);
    chk("int_flush_cycles", 32'(fl), 32'd0);
    chk("int_dv_cycles", 32'(dv), 32'd7);
    chk("int_first_cnt", 32'(c0), 32'd0);
    chk("int_last_cnt", 32'(cl), 32'd6);
    repeat (2) @(negedge clk);
    pulse_done(22'h3FFFFB, 32'hDEADBEEF);
    wait_res(k);
    chk("int_res_data", res_data, 32'hFFFFFFFB);
    chk("int_res_fp", 32'(res_fp), 32'd0);
    chk("int_res_err", 32'(res_err), 32'd0);
    take();

    // FP batch from INT: flush first.
    send(1'b1);
    run_phase(fl, dv, c0, cl);
    chk("fp_flush_cycles", 32'(fl), 32'd8);
    chk("fp_dv_cycles", 32'(dv), 32'd11);
    chk("fp_last_cnt", 32'(cl), 32'd10);
    pulse_done(22'h000123, 32'h3C40BC00);
    chk("fp_res_data", res_data, 32'h3C40BC00);
    chk("fp_res_fp", 32'(res_fp), 32'd1);
    take();

    // Timeout.
    send(1'b1);
    run_phase(fl, dv, c0, cl);
    wait_res(k);
    chk("timeout_latency", 32'(k), 32'd64);
    chk("timeout_err", 32'(res_err), 32'd1);
    chk("timeout_data", res_data, 32'd0);
    take();

    // Done coincident with timeout, then a long stall with a spurious done.
    send(1'b1);
    run_phase(fl, dv, c0, cl);
    repeat (63) @(negedge clk);
    pulse_done(22'h0, 32'h12345678);
    chk("tie_res_valid", 32'(res_valid), 32'd1);
    chk("tie_err", 32'(res_err), 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        cim_fp = 32'hAAAA5555;
        cim_done = 1'b1;
      end
      @(negedge clk);
      cim_done = 1'b0;
      chk("stall_data", res_data, 32'h12345678);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    take();

    // Back-to-back with res_ready held high (FP -> INT incurs a flush).
    res_ready = 1'b1;
    send(1'b0);
    run_phase(fl, dv, c0, cl);
    chk("b2b_flush_cycles", 32'(fl), 32'd8);
    pulse_done(22'h00007B, 32'h0);
    chk("b2b_res_data", res_data, 32'd123);
    @(negedge clk);
    chk("b2b_turnaround", 32'(cmd_ready), 32'd1);
    send(1'b0);
    run_phase(fl, dv, c0, cl);
    pulse_done(22'h200000, 32'h0);
    @(negedge clk);
    res_ready = 1'b0;

    // Reset mid-run at cnt==3 during an FP batch.
    send(1'b1);
    k = 0;
    while (!(cim_data_valid && cim_cnt == 4'd3) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_cnt3", 32'(cim_cnt), 32'd3);
    #2 RSTN = 1'b0;
    #1;
    chk("rst_async_cnt", 32'(cim_cnt), 32'hF);
    chk("rst_async_dv", 32'(cim_data_valid), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_infp", 32'(cim_infp), 32'd0);
    @(negedge clk);
    RSTN = 1'b1;
    @(negedge clk);
    send(1'b0);
    run_phase(fl, dv, c0, cl);
    chk("post_rst_flush", 32'(fl), 32'd0);
    chk("post_rst_first_cnt", 32'(c0), 32'd0);
    pulse_done(22'h000001, 32'h0);
    take();

`ifdef CIM_SEQ_PERF_EN
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b0);
      run_phase(fl, dv, c0, cl);
      pulse_done(22'(i), 32'h0);
      take();
    end
    send(1'b0);
    run_phase(fl, dv, c0, cl);
    wait_res(k);
    take();
    chk("perf_ops", perf_ops, 32'd3);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    chk("perf_ops_clr", perf_ops, 32'd0);
    chk("perf_cycles_clr", perf_cycles, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
